// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV64 sequencer and the datapath decoder:
// FSM states, opcode class constants and trap cause encodings.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_TRAP
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_ECALL  = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // One-hot instruction class; all-zero means illegal.
    typedef struct packed {
        logic r;
        logic i;
        logic load;
        logic store;
        logic branch;
        logic ecall;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Datapath/memory-port signal bundle between the sequencer (master) and the
// datapath it steers (slave).
interface multicycle_control_if #(parameter int CNT_W = 32);

    logic             start;
    logic [6:0]       opcode;
    logic             branch_taken;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_src;
    logic             ir_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src_imm;
    logic             mem_req;
    logic             mem_we;
    logic             busy;
    logic             halted;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;

    modport master (
        input  start, opcode, branch_taken, mem_ready,
        output pc_write, pc_src, ir_write, reg_write, mem_to_reg, alu_src_imm,
               mem_req, mem_we, busy, halted, trap, trap_cause, retired
    );

    modport slave (
        output start, opcode, branch_taken, mem_ready,
        input  pc_write, pc_src, ir_write, reg_write, mem_to_reg, alu_src_imm,
               mem_req, mem_we, busy, halted, trap, trap_cause, retired
    );

endinterface

// File: rtl/opcode_classify.sv
// Combinational opcode decoder: one-hot instruction class plus illegal flag.
module opcode_classify
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       illegal
);

    always_comb begin
        op_class        = '0;
        op_class.r      = (opcode == OPC_R);
        op_class.i      = (opcode == OPC_I);
        op_class.load   = (opcode == OPC_LOAD);
        op_class.store  = (opcode == OPC_STORE);
        op_class.branch = (opcode == OPC_BRANCH);
        op_class.ecall  = (opcode == OPC_ECALL);
        illegal         = (op_class == '0);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: steps FETCH/DECODE/EXEC/MEM/WB, drives per-state datapath
// strobes, bounds memory waits and counts retired instructions.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_control_if.master bus
);

    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state_reg;
    logic [6:0]        op_q_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic [1:0]        cause_reg;

    op_class_t  op_class;
    logic       op_illegal;
    logic [6:0] class_src;
    logic       mem_phase;
    logic       timeout_hit;
    logic       retire;

    // DECODE classifies the live IR opcode; every later state uses the latched copy.
    assign class_src = (state_reg == ST_DECODE) ? bus.opcode : op_q_reg;

    opcode_classify u_classify (
        .opcode   (class_src),
        .op_class (op_class),
        .illegal  (op_illegal)
    );

    assign mem_phase   = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
    assign timeout_hit = mem_phase && !bus.mem_ready && (wait_cnt_reg == WAIT_LAST);
    assign retire      = ((state_reg == ST_EXEC) && op_class.branch)
                      || ((state_reg == ST_MEM) && op_class.store && bus.mem_ready)
                      ||  (state_reg == ST_WB);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            op_q_reg     <= '0;
            wait_cnt_reg <= '0;
            retired_reg  <= '0;
            cause_reg    <= CAUSE_NONE;
        end else begin
            if (retire && (retired_reg != '1))
                retired_reg <= retired_reg + CNT_W'(1);

            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg    <= ST_FETCH;
                        wait_cnt_reg <= '0;
                    end
                end
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        state_reg <= ST_DECODE;
                    end else if (timeout_hit) begin
                        state_reg <= ST_TRAP;
                        cause_reg <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                ST_DECODE: begin
                    op_q_reg <= bus.opcode;
                    if (op_class.ecall) begin
                        state_reg <= ST_HALT;
                    end else if (op_illegal) begin
                        state_reg <= ST_TRAP;
                        cause_reg <= CAUSE_ILLEGAL;
                    end else begin
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_class.branch) begin
                        state_reg    <= ST_FETCH;
                        wait_cnt_reg <= '0;
                    end else if (op_class.load || op_class.store) begin
                        state_reg    <= ST_MEM;
                        wait_cnt_reg <= '0;
                    end else if (op_class.r || op_class.i) begin
                        state_reg <= ST_WB;
                    end else begin
                        state_reg <= ST_TRAP;
                        cause_reg <= CAUSE_ILLEGAL;
                    end
                end
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        if (op_class.store) begin
                            state_reg    <= ST_FETCH;
                            wait_cnt_reg <= '0;
                        end else begin
                            state_reg <= ST_WB;
                        end
                    end else if (timeout_hit) begin
                        state_reg <= ST_TRAP;
                        cause_reg <= CAUSE_TIMEOUT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                ST_WB: begin
                    state_reg    <= ST_FETCH;
                    wait_cnt_reg <= '0;
                end
                default: state_reg <= state_reg;
            endcase
        end
    end

    always_comb begin
        bus.pc_write    = 1'b0;
        bus.pc_src      = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.alu_src_imm = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.ir_write = bus.mem_ready;
            end
            ST_EXEC: begin
                bus.alu_src_imm = op_class.i || op_class.load || op_class.store;
                if (op_class.branch) begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = bus.branch_taken;
                end
            end
            ST_MEM: begin
                bus.mem_req     = 1'b1;
                bus.alu_src_imm = 1'b1;
                bus.mem_we      = op_class.store;
                bus.pc_write    = op_class.store && bus.mem_ready;
            end
            ST_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = op_class.load;
                bus.pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy       = (state_reg != ST_IDLE) && (state_reg != ST_HALT) && (state_reg != ST_TRAP);
    assign bus.halted     = (state_reg == ST_HALT);
    assign bus.trap       = (state_reg == ST_TRAP);
    assign bus.trap_cause = cause_reg;
    assign bus.retired    = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-level bench for multicycle_control: per-cycle vectors push expected strobes
// to a scoreboard queue that is popped and compared on the falling edge.
module tb_multicycle_control;
    import riscv_ctrl_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 3;

    // Strobe order: pc_write pc_src ir_write reg_write mem_to_reg alu_src_imm mem_req mem_we busy halted trap
    localparam logic [10:0] Z         = 11'b00000000000;
    localparam logic [10:0] F_WAIT    = 11'b00000010100;
    localparam logic [10:0] F_DONE    = 11'b00100010100;
    localparam logic [10:0] DEC       = 11'b00000000100;
    localparam logic [10:0] EX_R      = 11'b00000000100;
    localparam logic [10:0] EX_IMM    = 11'b00000100100;
    localparam logic [10:0] EX_BR_T   = 11'b11000000100;
    localparam logic [10:0] EX_BR_N   = 11'b10000000100;
    localparam logic [10:0] M_RD      = 11'b00000110100;
    localparam logic [10:0] M_ST      = 11'b00000111100;
    localparam logic [10:0] M_ST_DONE = 11'b10000111100;
    localparam logic [10:0] WB_R      = 11'b10010000100;
    localparam logic [10:0] WB_LD     = 11'b10011000100;
    localparam logic [10:0] HALT      = 11'b00000000010;
    localparam logic [10:0] TRAP      = 11'b00000000001;
    localparam logic [6:0]  J         = 7'h7F;

    typedef struct {
        logic       rst_n;
        logic       start;
        logic [6:0] op;
        logic       br;
        logic       rdy;
        logic [10:0] s;
        logic [1:0] c;
        logic [2:0] r;
        string      nm;
    } vec_t;

    typedef struct {
        logic [10:0] s;
        logic [1:0]  c;
        logic [2:0]  r;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus();

    multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t  sb_q[$];
    vec_t  tbl[$];
    int    errors = 0;
    int    checks = 0;
    exp_t  cur;
    logic [10:0] act_s;

    function automatic vec_t mk(input logic rst_n, input logic start, input logic [6:0] op,
                                input logic br, input logic rdy, input logic [10:0] s,
                                input logic [1:0] c, input logic [2:0] r, input string nm);
        vec_t v;
        v.rst_n = rst_n; v.start = start; v.op = op; v.br = br; v.rdy = rdy;
        v.s = s; v.c = c; v.r = r; v.nm = nm;
        return v;
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue its expected outputs.
    task automatic cyc(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n          = v.rst_n;
        bus.start        = v.start;
        bus.opcode       = v.op;
        bus.branch_taken = v.br;
        bus.mem_ready    = v.rdy;
        e.s = v.s; e.c = v.c; e.r = v.r; e.nm = v.nm;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string nm);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end else begin
            $display("ok   %s: value=%h", nm, got);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            cur   = sb_q.pop_front();
            act_s = {bus.pc_write, bus.pc_src, bus.ir_write, bus.reg_write, bus.mem_to_reg,
                     bus.alu_src_imm, bus.mem_req, bus.mem_we, bus.busy, bus.halted, bus.trap};
            checks++;
            if ({act_s, bus.trap_cause, bus.retired} !== {cur.s, cur.c, cur.r}) begin
                errors++;
                $display("FAIL %s: got strobes=%b cause=%b retired=%0d, expected strobes=%b cause=%b retired=%0d",
                         cur.nm, act_s, bus.trap_cause, bus.retired, cur.s, cur.c, cur.r);
            end else begin
                $display("ok   %s: strobes=%b cause=%b retired=%0d", cur.nm, act_s, bus.trap_cause, bus.retired);
            end
        end
    end

    initial begin
        bus.start = 1'b0; bus.opcode = '0; bus.branch_taken = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        // R, LOAD with waits, BRANCH taken/not, STORE, I, a fetch wait, then ECALL.
        tbl.push_back(mk(1, 0, J,          0, 0, Z,         0, 0, "reset_idle"));
        tbl.push_back(mk(1, 1, J,          0, 0, Z,         0, 0, "idle_start"));
        tbl.push_back(mk(1, 0, J,          0, 1, F_DONE,    0, 0, "r_fetch"));
        tbl.push_back(mk(1, 0, OPC_R,      0, 0, DEC,       0, 0, "r_decode"));
        tbl.push_back(mk(1, 1, J,          0, 0, EX_R,      0, 0, "r_exec"));
        tbl.push_back(mk(1, 0, J,          0, 0, WB_R,      0, 0, "r_wb"));
        tbl.push_back(mk(1, 0, J,          0, 1, F_DONE,    0, 1, "ld_fetch"));
        tbl.push_back(mk(1, 0, OPC_LOAD,   0, 0, DEC,       0, 1, "ld_decode"));
        tbl.push_back(mk(1, 0, J,          0, 0, EX_IMM,    0, 1, "ld_exec"));
        tbl.push_back(mk(1, 0, J,          0, 0, M_RD,      0, 1, "ld_mem_wait1"));
        tbl.push_back(mk(1, 0, J,          0, 0, M_RD,      0, 1, "ld_mem_wait2"));
        tbl.push_back(mk(1, 0, J,          0, 0, M_RD,      0, 1, "ld_mem_wait3"));
        tbl.push_back(mk(1, 0, J,          0, 1, M_RD,      0, 1, "ld_mem_done"));
        tbl.push_back(mk(1, 0, J,          0, 0, WB_LD,     0, 1, "ld_wb"));
        tbl.push_back(mk(1, 0, J,          0, 1, F_DONE,    0, 2, "bt_fetch"));
        tbl.push_back(mk(1, 0, OPC_BRANCH, 0, 0, DEC,       0, 2, "bt_decode"));
        tbl.push_back(mk(1, 0, J,          1, 0, EX_BR_T,   0, 2, "bt_exec"));
        tbl.push_back(mk(1, 0, J,          0, 1, F_DONE,    0, 3, "bn_fetch"));
        tbl.push_back(mk(1, 0, OPC_BRANCH, 1, 0, DEC,       0, 3, "bn_decode"));
        tbl.push_back(mk(1, 0, J,          0, 0, EX_BR_N,   0, 3, "bn_exec"));
        tbl.push_back(mk(1, 0, J,          0, 1, F_DONE,    0, 4, "st_fetch"));
        tbl.push_back(mk(1, 0, OPC_STORE,  0, 0, DEC,       0, 4, "st_decode"));
        tbl.push_back(mk(1, 0, J,          0, 0, EX_IMM,    0, 4, "st_exec"));
        tbl.push_back(mk(1, 0, J,          0, 1, M_ST_DONE, 0, 4, "st_mem"));
        tbl.push_back(mk(1, 0, J,          0, 1, F_DONE,    0, 5, "i_fetch"));
        tbl.push_back(mk(1, 0, OPC_I,      0, 0, DEC,       0, 5, "i_decode"));
        tbl.push_back(mk(1, 0, J,          0, 0, EX_IMM,    0, 5, "i_exec"));
        tbl.push_back(mk(1, 0, J,          0, 0, WB_R,      0, 5, "i_wb"));
        tbl.push_back(mk(1, 1, J,          0, 0, F_WAIT,    0, 6, "ec_fetch_wait"));
        tbl.push_back(mk(1, 0, J,          0, 1, F_DONE,    0, 6, "ec_fetch"));
        tbl.push_back(mk(1, 0, OPC_ECALL,  0, 0, DEC,       0, 6, "ec_decode"));
        tbl.push_back(mk(1, 1, J,          0, 1, HALT,      0, 6, "halt_start"));
        tbl.push_back(mk(1, 0, J,          0, 0, HALT,      0, 6, "halt_hold"));
        tbl.push_back(mk(0, 0, J,          0, 0, HALT,      0, 6, "halt_reset"));
        for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

        // Ready on the last allowed wait cycle wins, then a full fetch timeout.
        cyc(mk(1, 1, J, 0, 0, Z, 0, 0, "to_idle_start"));
        for (int k = 0; k < TIMEOUT - 1; k++) cyc(mk(1, 0, J, 0, 0, F_WAIT, 0, 0, "to_edge_wait"));
        cyc(mk(1, 0, J,     0, 1, F_DONE, 0, 0, "to_edge_ready"));
        cyc(mk(1, 0, OPC_R, 0, 0, DEC,    0, 0, "to_edge_decode"));
        cyc(mk(1, 0, J,     0, 0, EX_R,   0, 0, "to_edge_exec"));
        cyc(mk(1, 0, J,     0, 0, WB_R,   0, 0, "to_edge_wb"));
        for (int k = 0; k < TIMEOUT; k++) cyc(mk(1, 0, J, 0, 0, F_WAIT, 0, 1, "to_wait"));
        cyc(mk(1, 1, J, 0, 0, TRAP, CAUSE_TIMEOUT, 1, "to_trap_start"));
        @(negedge clk);
        #1;
        chk(32'({bus.trap, bus.busy, bus.trap_cause}), 32'({1'b1, 1'b0, CAUSE_TIMEOUT}), "expired_wait_trap");
        cyc(mk(1, 0, J, 0, 1, TRAP, CAUSE_TIMEOUT, 1, "to_trap_hold"));
        cyc(mk(0, 0, J, 0, 0, TRAP, CAUSE_TIMEOUT, 1, "to_trap_reset"));
        cyc(mk(1, 0, J, 0, 0, Z,    0,             0, "to_after_reset"));
        @(negedge clk);
        #1;
        chk(32'({bus.pc_write, bus.pc_src, bus.ir_write, bus.reg_write, bus.mem_to_reg,
                 bus.alu_src_imm, bus.mem_req, bus.mem_we, bus.busy, bus.halted, bus.trap,
                 bus.trap_cause, bus.retired}), 32'd0, "reset_state");

        // Illegal opcode traps with cause 01.
        cyc(mk(1, 1, J,       0, 0, Z,      0,             0, "ill_start"));
        cyc(mk(1, 0, J,       0, 1, F_DONE, 0,             0, "ill_fetch"));
        cyc(mk(1, 0, 7'h7F,   0, 0, DEC,    0,             0, "ill_decode"));
        cyc(mk(1, 1, J,       0, 1, TRAP,   CAUSE_ILLEGAL, 0, "ill_trap"));
        cyc(mk(0, 0, J,       0, 0, TRAP,   CAUSE_ILLEGAL, 0, "ill_reset"));
        cyc(mk(1, 0, J,       0, 0, Z,      0,             0, "ill_after_reset"));

        // Saturate the 3-bit counter, then reset in the middle of a store's MEM wait.
        cyc(mk(1, 1, J, 0, 0, Z, 0, 0, "sat_start"));
        for (int k = 0; k < 8; k++) begin
            cyc(mk(1, 0, J,     0, 1, F_DONE, 0, 3'(k), "sat_fetch"));
            cyc(mk(1, 0, OPC_R, 0, 0, DEC,    0, 3'(k), "sat_decode"));
            cyc(mk(1, 0, J,     0, 0, EX_R,   0, 3'(k), "sat_exec"));
            cyc(mk(1, 0, J,     0, 0, WB_R,   0, 3'(k), "sat_wb"));
        end
        cyc(mk(1, 0, J,         0, 1, F_DONE, 0, 7, "sat_hold_fetch"));
        cyc(mk(1, 0, OPC_STORE, 0, 0, DEC,    0, 7, "mr_decode"));
        cyc(mk(1, 0, J,         0, 0, EX_IMM, 0, 7, "mr_exec"));
        cyc(mk(1, 0, J,         0, 0, M_ST,   0, 7, "mr_mem_wait"));
        cyc(mk(0, 0, J,         0, 0, M_ST,   0, 7, "mr_mem_reset"));
        cyc(mk(1, 0, J,         0, 1, Z,      0, 0, "mr_after_reset"));

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
